banked_rf: RTL and testbench

Parametrised multi-bank register file for the decode stage; generalises the fixed user/supervisor pair of 32x32 files into BANKS identical banks sharing one write port and two read ports. Adds an optional write-to-read bypass and a sequential bank-clear engine that zeroes one bank, one register per cycle, under a busy/done handshake. Sits in the ID stage; the privilege/context logic drives the bank selects.

---
 rtl/banked_rf_pkg.sv | 15 +
 rtl/banked_rf_clr_fsm.sv | 72 +++++++
 rtl/banked_rf.sv | 94 +++++++++
 tb/tb_banked_rf.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_rf_pkg.sv
// Shared types and helpers for the banked register file and its clear engine.
package banked_rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Bank-select width; a single bank still needs a 1-bit select port.
    function automatic int bank_bits(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/banked_rf_clr_fsm.sv
// Sequential bank-clear engine: zeroes registers 1..DEPTH-1 of one captured bank,
// one register per cycle, with a busy/done handshake.
module banked_rf_clr_fsm
    import banked_rf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int BANKS = 2,
    parameter int AW    = 5,
    parameter int BW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic [BW-1:0] clr_bank,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic [BW-1:0] clr_bank_q
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bank_d;
    logic          bank_ok;

    assign bank_ok  = int'(clr_bank) < BANKS;
    assign clr_busy = (state_q != IDLE);
    assign clr_addr = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_bank_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_bank_q <= bank_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = clr_bank_q;
        clr_we   = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Register 0 is hardwired to zero, so the sweep starts at 1.
                if (clr_req && bank_ok) begin
                    bank_d  = clr_bank;
                    cnt_d   = AW'(1);
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1))
                    state_d = DONE;
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/banked_rf.sv
// Multi-bank register file: one write port, two combinational read ports, bank clear engine.
// Define BANKED_RF_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module banked_rf
    import banked_rf_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    parameter  int BANKS = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = bank_bits(BANKS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BW-1:0]    rd_bank,
    input  logic [AW-1:0]    rd1_addr,
    input  logic [AW-1:0]    rd2_addr,
    output logic [WIDTH-1:0] data1_out,
    output logic [WIDTH-1:0] data2_out,
    input  logic             wr_n,
    input  logic [BW-1:0]    wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_req,
    input  logic [BW-1:0]    clr_bank,
    output logic             clr_busy,
    output logic             clr_done
);

    logic [BANKS-1:0][DEPTH-1:0][WIDTH-1:0] mem;
    logic                                   clr_we;
    logic [AW-1:0]                          clr_addr;
    logic [BW-1:0]                          clr_bank_q;
    logic                                   ext_we;

    banked_rf_clr_fsm #(
        .DEPTH (DEPTH),
        .BANKS (BANKS),
        .AW    (AW),
        .BW    (BW)
    ) u_clr (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_bank   (clr_bank),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr),
        .clr_bank_q (clr_bank_q)
    );

    // The bank under clear is locked against external writes for the whole busy window.
    assign ext_we = !wr_n && (int'(wr_bank) < BANKS) && (wr_addr != '0) &&
                    !(clr_busy && (wr_bank == clr_bank_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (ext_we && (wr_bank == BW'(b)))
                    mem[b][wr_addr] <= data_in;
                if (clr_we && (clr_bank_q == BW'(b)))
                    mem[b][clr_addr] <= '0;
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(
        input logic [BANKS-1:0][DEPTH-1:0][WIDTH-1:0] m,
        input logic [BW-1:0]                          bank,
        input logic [AW-1:0]                          addr
    );
        logic [WIDTH-1:0] val;
        val = '0;
        for (int b = 0; b < BANKS; b++)
            if ((bank == BW'(b)) && (addr != '0))
                val = m[b][addr];
        return val;
    endfunction

    always_comb begin
        data1_out = read_port(mem, rd_bank, rd1_addr);
        data2_out = read_port(mem, rd_bank, rd2_addr);
`ifdef BANKED_RF_BYPASS_EN
        // ext_we already excludes address 0, invalid banks and locked writes.
        if (ext_we && (wr_bank == rd_bank) && (wr_addr == rd1_addr))
            data1_out = data_in;
        if (ext_we && (wr_bank == rd_bank) && (wr_addr == rd2_addr))
            data2_out = data_in;
`endif
    end

endmodule

// File: tb/tb_banked_rf.sv
// Randomized/directed bench for banked_rf against an array-based reference model.
module tb_banked_rf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int BANKS = 2;
    localparam int AW    = 5;
    localparam int BW    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [BW-1:0]    rd_bank, wr_bank, clr_bank;
    logic [AW-1:0]    rd1_addr, rd2_addr, wr_addr;
    logic [WIDTH-1:0] data1_out, data2_out, data_in;
    logic             wr_n, clr_req, clr_busy, clr_done;

    logic [1:0]       rd_bank3, wr_bank3, clr_bank3;
    logic [WIDTH-1:0] d3_1, d3_2;
    logic             wr_n3, clr_req3, busy3, done3;

    banked_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
        .clk(clk), .reset(reset), .rd_bank(rd_bank), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .data1_out(data1_out), .data2_out(data2_out), .wr_n(wr_n), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .data_in(data_in), .clr_req(clr_req), .clr_bank(clr_bank),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    banked_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(3)) dut3 (
        .clk(clk), .reset(reset), .rd_bank(rd_bank3), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .data1_out(d3_1), .data2_out(d3_2), .wr_n(wr_n3), .wr_bank(wr_bank3),
        .wr_addr(wr_addr), .data_in(data_in), .clr_req(clr_req3), .clr_bank(clr_bank3),
        .clr_busy(busy3), .clr_done(done3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain storage plus the clear's age in cycles since acceptance (-1 = idle).
    logic [31:0] m [BANKS][DEPTH];
    int          age;
    int          cb;

    function automatic void model_reset();
        for (int b = 0; b < BANKS; b++)
            for (int a = 0; a < DEPTH; a++)
                m[b][a] = '0;
        age = -1;
        cb  = 0;
    endfunction

    function automatic bit wr_ok();
        return !wr_n && int'(wr_bank) < BANKS && wr_addr != 0 &&
               !(age >= 0 && int'(wr_bank) == cb);
    endfunction

    function automatic logic [31:0] exp_rd(input int bank, input int addr);
        if (bank >= BANKS || addr == 0) return '0;
`ifdef BANKED_RF_BYPASS_EN
        if (wr_ok() && int'(wr_bank) == bank && int'(wr_addr) == addr) return data_in;
`endif
        return m[bank][addr];
    endfunction

    function automatic void model_edge();
        bit busy;
        bit start;
        busy  = age >= 0;
        start = !busy && clr_req && int'(clr_bank) < BANKS;
        if (wr_ok()) m[int'(wr_bank)][int'(wr_addr)] = data_in;
        if (busy) begin
            age++;
            if (age <= DEPTH - 1) m[cb][age] = '0;
            if (age == DEPTH) age = -1;
        end
        if (start) begin
            age = 0;
            cb  = int'(clr_bank);
        end
    endfunction

    // Called at a falling edge with inputs set; checks reads, clocks once, checks handshake.
    task automatic step();
        #1;
        chk("rd1", data1_out, exp_rd(int'(rd_bank), int'(rd1_addr)));
        chk("rd2", data2_out, exp_rd(int'(rd_bank), int'(rd2_addr)));
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        chk("busy", 32'(clr_busy), 32'(age >= 0));
        chk("done", 32'(clr_done), 32'(age == DEPTH - 1));
    endtask

    task automatic wr(input int bank, input int addr, input logic [31:0] d);
        wr_bank = BW'(bank);
        wr_addr = AW'(addr);
        data_in = d;
        wr_n    = 1'b0;
        step();
        wr_n    = 1'b1;
    endtask

    task automatic rand_inputs();
        wr_n     = $urandom_range(0, 1) == 0;
        wr_bank  = BW'($urandom_range(0, BANKS - 1));
        wr_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, DEPTH - 1));
        data_in  = $urandom;
        rd_bank  = BW'($urandom_range(0, BANKS - 1));
        rd1_addr = $urandom_range(0, 1) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
        rd2_addr = AW'($urandom_range(0, DEPTH - 1));
        clr_bank = BW'($urandom_range(0, BANKS - 1));
    endtask

    int busy_cnt, done_cnt;

    initial begin
        reset = 1'b0;
        wr_n = 1'b1; wr_bank = '0; wr_addr = '0; data_in = '0;
        rd_bank = 1'b1; rd1_addr = 5; rd2_addr = 0;
        clr_req = 1'b0; clr_bank = '0;
        wr_n3 = 1'b1; wr_bank3 = '0; rd_bank3 = '0; clr_req3 = 1'b0; clr_bank3 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(clr_busy), 32'(0));
        chk("rst_done", 32'(clr_done), 32'(0));
        chk("rst_rd", data1_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Three-bank instance: bank 3 does not exist.
        wr_addr = 5; data_in = 32'h1111_2222; wr_bank3 = 2'd2; wr_n3 = 1'b0;
        @(negedge clk);
        data_in = 32'h3333_4444; wr_bank3 = 2'd3; clr_req3 = 1'b1; clr_bank3 = 2'd3;
        @(negedge clk);
        wr_n3 = 1'b1; clr_req3 = 1'b0;
        rd1_addr = 5; rd2_addr = 5; rd_bank3 = 2'd3;
        #1;
        chk("b3_busy", 32'(busy3), 32'(0));
        chk("b3_rd1", d3_1, 32'h0);
        chk("b3_rd2", d3_2, 32'h0);
        rd_bank3 = 2'd2;
        #1;
        chk("b2_rd", d3_1, 32'h1111_2222);
        rd_bank3 = 2'd0;
        #1;
        chk("b0_rd_b3", d3_1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b3_busy_hold", 32'(busy3), 32'(0));
            chk("b3_done_hold", 32'(done3), 32'(0));
        end
        @(negedge clk);

        // Per-bank separation.
        wr(1, 5, 32'hDEAD_BEEF);
        wr(0, 5, 32'h1234_5678);
        rd_bank = 1'b1; rd1_addr = 5;
        #1 chk("tp_b1", data1_out, 32'hDEAD_BEEF);
        rd_bank = 1'b0;
        #1 chk("tp_b0", data1_out, 32'h1234_5678);
        @(negedge clk);

        // Address 0 is hardwired.
        wr(0, 0, 32'hFFFF_FFFF);
        wr(1, 0, 32'hFFFF_FFFF);
        for (int b = 0; b < BANKS; b++) begin
            rd_bank = BW'(b); rd1_addr = 0; rd2_addr = 0;
            #1;
            chk("a0_rd1", data1_out, 32'h0);
            chk("a0_rd2", data2_out, 32'h0);
        end
        @(negedge clk);

        // Same-cycle write/read.
        rd_bank = 1'b0; rd1_addr = 7; rd2_addr = 7;
        wr_bank = 1'b0; wr_addr = 7; data_in = 32'hA5A5_A5A5; wr_n = 1'b0;
        #1;
`ifdef BANKED_RF_BYPASS_EN
        chk("byp_same", data1_out, 32'hA5A5_A5A5);
`else
        chk("byp_same", data1_out, 32'h0);
`endif
        step();
        wr_n = 1'b1;
        #1 chk("byp_next", data1_out, 32'hA5A5_A5A5);
        @(negedge clk);

        // Fill bank 1, then clear it while hammering both banks.
        for (int i = 1; i < DEPTH; i++) wr(1, i, $urandom | 32'h1);
        clr_req = 1'b1; clr_bank = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 36; c++) begin
            if (c == 6) clr_req = 1'b0;
            rand_inputs();
            if (c == 0) clr_bank = 1'b1;
            wr_addr = AW'($urandom_range(1, DEPTH - 1));
            if (c > 32) wr_n = 1'b1;
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        wr_n = 1'b1; clr_req = 1'b0;
        chk("busy_len", busy_cnt, 32'd32);
        chk("done_cnt", done_cnt, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_bank = 1'b1; rd1_addr = AW'(i); rd2_addr = AW'(i);
            #1 chk("clr_zero", data1_out, 32'h0);
            @(negedge clk);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_bank = 1'b0; rd1_addr = AW'(i); rd2_addr = AW'(DEPTH - 1 - i);
            step();
        end

        // Reset in the middle of a clear of bank 0.
        clr_req = 1'b1; clr_bank = 1'b0;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        reset = 1'b0;
        rd_bank = 1'b0; rd1_addr = 5;
        #1;
        chk("mid_rst_busy", 32'(clr_busy), 32'(0));
        chk("mid_rst_done", 32'(clr_done), 32'(0));
        chk("mid_rst_rd", data1_out, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            rd_bank = BW'(i / DEPTH); rd1_addr = AW'(i % DEPTH); rd2_addr = AW'((i * 7) % DEPTH);
            step();
            if (clr_done) done_cnt++;
        end
        chk("no_done_after_rst", done_cnt, 32'd0);

        // Random traffic with occasional clears.
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            clr_req = $urandom_range(0, 29) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
